// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: walks WIDTH-bit operands CHUNK bits per clock
// through one shared ripple chain and a registered carry, with ready/valid on both sides.
module serial_adder_sub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int STEPS  = WIDTH / CHUNK;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   generate
      if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
         $error("serial_adder_sub: WIDTH must be >= 2 and an exact multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  a_reg, b_reg, res_reg, res_next, sum_reg;
   logic              carry_reg, cout_reg, overflow_reg;
   logic [STEP_W-1:0] step_reg;

   logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
   logic              carry_v, carry_msb_in, carry_out;
   logic              last_step;

   assign last_step = (step_reg == LAST_STEP);
   assign a_chunk   = a_reg[int'(step_reg) * CHUNK +: CHUNK];
   assign b_chunk   = b_reg[int'(step_reg) * CHUNK +: CHUNK];

   // Ripple chain for one chunk; the carry into its top bit feeds overflow on the final step.
   always_comb begin
      carry_v      = carry_reg;
      carry_msb_in = carry_reg;
      s_chunk      = '0;
      for (int i = 0; i < CHUNK; i++) begin
         carry_msb_in = carry_v;
         s_chunk[i]   = a_chunk[i] ^ b_chunk[i] ^ carry_v;
         carry_v      = (a_chunk[i] & b_chunk[i]) | (carry_v & (a_chunk[i] ^ b_chunk[i]));
      end
      carry_out = carry_v;
   end

   generate
      for (genvar gi = 0; gi < STEPS; gi++) begin : g_slot
         assign res_next[gi*CHUNK +: CHUNK] =
            (step_reg == STEP_W'(gi)) ? s_chunk : res_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (last_step) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Subtract is a + ~b + !cin, so the operand and carry are conditioned once at accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg        <= '0;
         b_reg        <= '0;
         res_reg      <= '0;
         carry_reg    <= 1'b0;
         step_reg     <= '0;
         sum_reg      <= '0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= sub ? ~b : b;
                  carry_reg <= sub ? ~cin : cin;
                  step_reg  <= '0;
                  res_reg   <= '0;
               end
            end
            RUN: begin
               res_reg   <= res_next;
               carry_reg <= carry_out;
               step_reg  <= step_reg + 1'b1;
               if (last_step) begin
                  sum_reg      <= res_next;
                  cout_reg     <= carry_out;
                  overflow_reg <= carry_msb_in ^ carry_out;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum      = sum_reg;
   assign cout     = cout_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: CHUNK=1 and CHUNK=4 instances side by side, with a
// scoreboard queue filled at the accept edge and drained when out_valid is seen.
module tb_serial_adder_sub;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      in_valid, in_ready, out_valid, out_ready, cout, overflow;
   logic [1:0][7:0] sum;
   logic [7:0]      a, b;
   logic            cin, sub;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_adder_sub #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum[0]), .cout(cout[0]), .overflow(overflow[0])
   );

   serial_adder_sub #(.WIDTH(8), .CHUNK(4)) u_dut_c4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum[1]), .cout(cout[1]), .overflow(overflow[1])
   );

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                  input logic ci, input logic s_op);
      logic [8:0] full;
      exp_t       e;
      if (!s_op) begin
         full  = {1'b0, x} + {1'b0, y} + 9'(ci);
         e.ovf = (x[7] == y[7]) && (full[7] != x[7]);
      end else begin
         full  = {1'b0, x} + {1'b0, ~y} + 9'(!ci);
         e.ovf = (x[7] != y[7]) && (full[7] != x[7]);
      end
      e.sum  = full[7:0];
      e.cout = full[8];
      return e;
   endfunction

   // Offers one operand set and returns on the falling edge after the accept edge,
   // then scrambles the operand bus so late changes would corrupt a non-isolated DUT.
   task automatic send(input int u, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic s_op);
      int n = 0;
      @(negedge clk);
      while (!in_ready[u] && n < 64) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready[u] !== 1'b1) begin
         errors++;
         $display("FAIL send_ready unit %0d: in_ready=%b required 1", u, in_ready[u]);
      end
      a = x; b = y; cin = ci; sub = s_op;
      in_valid[u] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[u] = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
   endtask

   task automatic wait_valid(input int u, output int lat);
      lat = 0;
      while (!out_valid[u] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = '0; out_ready = '0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checks++;
         if ({in_ready[u], out_valid[u], sum[u], cout[u], overflow[u]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state unit %0d: rdy=%b vld=%b sum=%h cout=%b ovf=%b required rdy=1 vld=0 sum=00 cout=0 ovf=0",
                     u, in_ready[u], out_valid[u], sum[u], cout[u], overflow[u]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_vectors(input int u);
      logic [7:0] ta[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
      logic [7:0] tb[4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
      logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic       ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_t       te[4] = '{{8'h96, 1'b0, 1'b1}, {8'h01, 1'b1, 1'b0},
                            {8'hF0, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}};
      int         steps = (u == 0) ? 8 : 2;
      int         lat;
      exp_t       got;
      for (int i = 0; i < 4; i++) begin
         send(u, ta[i], tb[i], tc[i], ts[i]);
         sb.push_back(te[i]);
         wait_valid(u, lat);
         checks++;
         if (lat != steps) begin
            errors++;
            $display("FAIL latency unit %0d vec %0d: edges=%0d required %0d", u, i, lat, steps);
         end
         got = sb.pop_front();
         checks++;
         if ({sum[u], cout[u], overflow[u]} !== got) begin
            errors++;
            $display("FAIL vector unit %0d vec %0d: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     u, i, sum[u], cout[u], overflow[u], got.sum, got.cout, got.ovf);
         end
         $display("unit %0d vec %0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b edges=%0d",
                  u, i, ta[i], tb[i], tc[i], ts[i], sum[u], cout[u], overflow[u], lat);
         out_ready[u] = 1'b1;
         @(negedge clk);
         out_ready[u] = 1'b0;
         checks++;
         if ({out_valid[u], in_ready[u], sum[u]} !== {1'b0, 1'b1, got.sum}) begin
            errors++;
            $display("FAIL handshake unit %0d vec %0d: vld=%b rdy=%b sum=%h required vld=0 rdy=1 sum=%h",
                     u, i, out_valid[u], in_ready[u], sum[u], got.sum);
         end
      end
   endtask

   task automatic test_random(input int u, input int n);
      int         lat;
      exp_t       got;
      logic [7:0] x, y;
      logic       ci, s_op;
      for (int i = 0; i < n; i++) begin
         x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); s_op = 1'($urandom);
         send(u, x, y, ci, s_op);
         sb.push_back(model(x, y, ci, s_op));
         wait_valid(u, lat);
         got = sb.pop_front();
         checks++;
         if ({sum[u], cout[u], overflow[u]} !== got || lat != ((u == 0) ? 8 : 2)) begin
            errors++;
            $display("FAIL random unit %0d: a=%h b=%h cin=%b sub=%b sum=%h cout=%b ovf=%b edges=%0d required sum=%h cout=%b ovf=%b",
                     u, x, y, ci, s_op, sum[u], cout[u], overflow[u], lat, got.sum, got.cout, got.ovf);
         end
         $display("unit %0d rand a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b",
                  u, x, y, ci, s_op, sum[u], cout[u], overflow[u]);
         out_ready[u] = 1'b1;
         @(negedge clk);
         out_ready[u] = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      int   lat;
      exp_t got;
      send(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
      sb.push_back(model(8'h5A, 8'h3C, 1'b0, 1'b0));
      wait_valid(0, lat);
      got = sb.pop_front();
      a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({sum[0], cout[0], overflow[0], in_ready[0], out_valid[0]} !== {got, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL backpressure cycle %0d: sum=%h cout=%b ovf=%b rdy=%b vld=%b required sum=%h cout=%b ovf=%b rdy=0 vld=1",
                     i, sum[0], cout[0], overflow[0], in_ready[0], out_valid[0], got.sum, got.cout, got.ovf);
         end
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      checks++;
      if ({in_ready[0], out_valid[0]} !== 2'b10) begin
         errors++;
         $display("FAIL bp_release: rdy=%b vld=%b required rdy=1 vld=0", in_ready[0], out_valid[0]);
      end
      sb.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      wait_valid(0, lat);
      got = sb.pop_front();
      checks++;
      if ({sum[0], cout[0], overflow[0]} !== got || lat != 8) begin
         errors++;
         $display("FAIL bp_new_op: sum=%h cout=%b ovf=%b edges=%0d required sum=%h cout=%b ovf=%b edges=8",
                  sum[0], cout[0], overflow[0], lat, got.sum, got.cout, got.ovf);
      end
      $display("backpressure new op -> sum=%h edges=%0d", sum[0], lat);
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int   lat;
      int   pulses = 0;
      exp_t got;
      send(0, 8'hFF, 8'h01, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready[0], out_valid[0], sum[0], cout[0], overflow[0]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b vld=%b sum=%h cout=%b ovf=%b required rdy=1 vld=0 sum=00 cout=0 ovf=0",
                  in_ready[0], out_valid[0], sum[0], cout[0], overflow[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid[0]) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL aborted_op: out_valid cycles=%0d required 0", pulses);
      end
      send(0, 8'h01, 8'h01, 1'b0, 1'b0);
      sb.push_back('{8'h02, 1'b0, 1'b0});
      wait_valid(0, lat);
      got = sb.pop_front();
      checks++;
      if ({sum[0], cout[0], overflow[0]} !== got || lat != 8) begin
         errors++;
         $display("FAIL post_reset_op: sum=%h cout=%b ovf=%b edges=%0d required sum=%h cout=%b ovf=%b edges=8",
                  sum[0], cout[0], overflow[0], lat, got.sum, got.cout, got.ovf);
      end
      $display("post-reset 01+01 -> sum=%h edges=%0d", sum[0], lat);
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vectors(0);
      test_vectors(1);
      test_random(0, 10);
      test_random(1, 10);
      test_backpressure();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
